// File: rtl/truth_table_sequencer.sv
// rtl/truth_table_sequencer.sv - sweeps 3/4-input vectors into two function
// implementations and reports mismatch count, first failing vector and pass.
module truth_table_sequencer #(
  parameter int STEP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       n_sel,
  input  logic       y1,
  input  logic       y2,
  output logic [3:0] vec,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] mism_count,
  output logic [3:0] first_fail,
  output logic       fail_valid
);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(STEP_CYCLES - 1);

  state_t     state, state_next;
  logic [3:0] hold;
  logic [3:0] last;
  logic       accept;
  logic       sample;
  logic       mismatch;

  assign mismatch = y1 ^ y2;
  assign busy     = (state == DRIVE);
  assign done     = (state == DONE);

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    sample     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = DRIVE;
          accept     = 1'b1;
        end
      end
      DRIVE: begin
        if (hold == HOLD_LAST) begin
          sample = 1'b1;
          if (vec == last) state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      vec        <= 4'd0;
      hold       <= 4'd0;
      last       <= 4'd0;
      pass       <= 1'b0;
      mism_count <= 5'd0;
      first_fail <= 4'd0;
      fail_valid <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        vec        <= 4'd0;
        hold       <= 4'd0;
        last       <= n_sel ? 4'd15 : 4'd7;
        pass       <= 1'b0;
        mism_count <= 5'd0;
        first_fail <= 4'd0;
        fail_valid <= 1'b0;
      end else if (sample) begin
        hold <= 4'd0;
        if (vec != last) vec <= vec + 4'd1;
        if (mismatch) begin
          if (mism_count != 5'd16) mism_count <= mism_count + 5'd1;
          if (!fail_valid) begin
            first_fail <= vec;
            fail_valid <= 1'b1;
          end
        end
        // Final sample: pass must account for a mismatch on this very edge.
        if (vec == last) pass <= (mism_count == 5'd0) && !mismatch;
      end else if (state == DRIVE) begin
        hold <= hold + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb/tb_truth_table_sequencer.sv - self-checking bench for truth_table_sequencer.
module tb_truth_table_sequencer;

  localparam int S = 2;

  logic clk = 1'b0;
  logic reset, start, n_sel, start1;
  logic [15:0] fault, fault1;
  logic y1, y2, y1b, y2b;
  logic [3:0] vec, first_fail, vec1, first_fail1;
  logic [4:0] mism_count, mism_count1;
  logic busy, done, pass, fail_valid;
  logic busy1, done1, pass1, fail_valid1;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  // Reference function under test, with a per-vector fault injected into y2.
  assign y1  = vec[3] ^ (vec[2] & vec[1]) ^ vec[0];
  assign y2  = y1 ^ fault[vec];
  assign y1b = vec1[3] ^ (vec1[2] & vec1[1]) ^ vec1[0];
  assign y2b = y1b ^ fault1[vec1];

  truth_table_sequencer #(.STEP_CYCLES(S)) u_dut (
    .clk(clk), .reset(reset), .start(start), .n_sel(n_sel), .y1(y1), .y2(y2),
    .vec(vec), .busy(busy), .done(done), .pass(pass), .mism_count(mism_count),
    .first_fail(first_fail), .fail_valid(fail_valid)
  );

  truth_table_sequencer #(.STEP_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .n_sel(1'b0), .y1(y1b), .y2(y2b),
    .vec(vec1), .busy(busy1), .done(done1), .pass(pass1), .mism_count(mism_count1),
    .first_fail(first_fail1), .fail_valid(fail_valid1)
  );

  typedef struct {
    logic        ns;
    logic [15:0] mask;
    bit          disturb;
    int          exp_mism;
    int          exp_first;
    logic        exp_fv;
    logic        exp_pass;
  } tv_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Expected results straight from the sweep definition: count faulty vectors in range.
  task automatic model(input logic ns, input logic [15:0] mask,
                       output int m, output int f, output logic fv, output logic p);
    int lastv;
    lastv = ns ? 15 : 7;
    m = 0; f = 0; fv = 1'b0;
    for (int i = 0; i <= lastv; i++) begin
      if (mask[i]) begin
        if (!fv) f = i;
        fv = 1'b1;
        m++;
      end
    end
    p = (m == 0);
  endtask

  task automatic run_sweep(input string name, input logic ns, input logic [15:0] mask,
                           input bit disturb, input int em, input int ef,
                           input logic efv, input logic ep);
    int v, dones, exp_vec;
    bit trace_ok;
    v = ns ? 16 : 8;
    fault = mask; n_sel = ns; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    trace_ok = 1; dones = 0;
    for (int k = 0; k <= v * S; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (disturb && k == 3 * S) begin start = 1'b1; n_sel = ~ns; end
      else if (disturb && k == 3 * S + 1) begin start = 1'b0; n_sel = ns; end
      exp_vec = (k == v * S) ? v - 1 : k / S;
      if (vec !== 4'(exp_vec)) trace_ok = 0;
      if (busy !== (k < v * S)) trace_ok = 0;
      if (done !== (k == v * S)) trace_ok = 0;
      if (done) dones++;
    end
    check({name, "_trace"}, 32'(trace_ok), 32'd1);
    check({name, "_mism"}, 32'(mism_count), 32'(em));
    check({name, "_first"}, {31'd0, fail_valid} << 4 | 32'(first_fail), {31'd0, efv} << 4 | 32'(ef));
    check({name, "_pass"}, 32'(pass), 32'(ep));
    repeat (3) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check({name, "_dones"}, 32'(dones), 32'd1);
    check({name, "_persist"}, {mism_count, first_fail, fail_valid, pass, busy},
          {5'(em), 4'(ef), efv, ep, 1'b0});
  endtask

  tv_t tbl[5];

  initial begin
    int m, f, dc;
    logic fv, p, ns;
    logic [15:0] mask;

    tbl[0] = '{1'b1, 16'h0000, 1'b0, 0, 0, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 16'h0220, 1'b0, 2, 5, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 16'hFFFF, 1'b0, 8, 0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 16'hFF00, 1'b0, 0, 0, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 16'hFFFF, 1'b1, 16, 0, 1'b1, 1'b0};

    reset = 1'b1; start = 1'b0; start1 = 1'b0; n_sel = 1'b0;
    fault = 16'h0; fault1 = 16'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_state", {vec, busy, done, pass, mism_count, first_fail, fail_valid}, 32'd0);

    foreach (tbl[i])
      run_sweep($sformatf("tbl%0d", i), tbl[i].ns, tbl[i].mask, tbl[i].disturb,
                tbl[i].exp_mism, tbl[i].exp_first, tbl[i].exp_fv, tbl[i].exp_pass);

    // Mid-sweep start / n_sel toggle on a sweep with two mismatches.
    run_sweep("disturb", 1'b1, 16'h0220, 1'b1, 2, 5, 1'b1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      ns = 1'($urandom_range(0, 1));
      mask = 16'($urandom);
      if (r == 0) mask = 16'h0;
      model(ns, mask, m, f, fv, p);
      run_sweep($sformatf("rand%0d", r), ns, mask, 1'b0, m, f, fv, p);
    end

    // Reset while vec=6 discards the sweep without a done pulse.
    fault = 16'h0006; n_sel = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 100 && vec != 4'd6; i++) begin @(posedge clk); #1; end
    check("rst_reach_vec6", 32'(vec), 32'd6);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_outputs", {vec, busy, done, pass, mism_count, first_fail, fail_valid}, 32'd0);
    dc = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dc++;
    end
    check("rst_no_done", 32'(dc), 32'd0);
    run_sweep("after_rst", 1'b1, 16'h0400, 1'b0, 1, 10, 1'b1, 1'b0);

    // STEP_CYCLES=1, 3-input, only the final vector mismatches.
    fault1 = 16'h0080; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    dc = 0;
    for (int k = 1; k < 8; k++) begin
      if (done1 || vec1 !== 4'(k - 1)) dc++;
      @(posedge clk); #1;
    end
    if (done1 || vec1 !== 4'd7) dc++;
    check("s1_trace", 32'(dc), 32'd0);
    @(posedge clk); #1;
    check("s1_done", 32'(done1), 32'd1);
    check("s1_result", {mism_count1, first_fail1, fail_valid1, pass1, vec1},
          {5'd1, 4'd7, 1'b1, 1'b0, 4'd7});
    @(posedge clk); #1;
    check("s1_done_single", 32'(done1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
